// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: pipeline enable/clear/PC control for hazards, multi-cycle ops, redirects and traps
// Inputs : decode sources (rs1_id, rs2_id, use_rs_id), EXE info (rd_exe, mem_read_exe, mc_start_exe),
//          mc_done, redirect_mem, stall_pipl, trap_taken, mret_exec
// Outputs: stage_en/stage_clr per pipeline register, pc_reg_en, mc_abort pulse,
//          sticky mc_timeout, fsm_state (RUN=0, MC_BUSY=1, FLUSH=2)
// Optional: PIPE_PERF_CNT_EN adds stall_cycles and flush_events counters
module pipe_flow_ctrl #(
    parameter int NUM_STAGES   = 5,
    parameter int EXE_STAGE    = 2,
    parameter int BR_STAGE     = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int MC_TIMEOUT   = 64,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [1:0]            use_rs_id,
    input  logic [REG_ADDR_W-1:0] rd_exe,
    input  logic                  mem_read_exe,
    input  logic                  mc_start_exe,
    input  logic                  mc_done,
    input  logic                  redirect_mem,
    input  logic                  stall_pipl,
    input  logic                  trap_taken,
    input  logic                  mret_exec,
    output logic [NUM_STAGES-2:0] stage_en,
    output logic [NUM_STAGES-2:0] stage_clr,
    output logic                  pc_reg_en,
    output logic                  mc_abort,
    output logic                  mc_timeout,
    output logic [1:0]            fsm_state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events
`endif
);
    localparam int N = NUM_STAGES - 1;
    // freeze: hold registers 0..EXE_STAGE-1, inject a bubble into register EXE_STAGE
    localparam logic [N-1:0] FRZ_EN  = ~N'((1 << EXE_STAGE) - 1);
    localparam logic [N-1:0] FRZ_CLR = N'(1 << EXE_STAGE);
    // load-use: hold register EXE_STAGE-2 (none when EXE_STAGE==1), bubble register EXE_STAGE-1
    localparam logic [N-1:0] LU_EN   = ~N'((1 << EXE_STAGE) >> 2);
    localparam logic [N-1:0] LU_CLR  = N'(1 << (EXE_STAGE - 1));
    localparam logic [N-1:0] BR_CLR  = N'((1 << BR_STAGE) - 1);
    localparam logic [7:0]   MC_MAX  = 8'(MC_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN = 2'd0, MC_BUSY = 2'd1, FLUSH = 2'd2} state_t;

    state_t       state, state_nx;
    logic [3:0]   flush_cnt, flush_cnt_nx;
    logic [7:0]   mc_cnt, mc_cnt_nx;
    logic [N-1:0] en, clr;
    logic         pc_en, abort, set_to, load_use;

    assign load_use = mem_read_exe && rd_exe != '0 &&
                      ((use_rs_id[0] && rs1_id == rd_exe) || (use_rs_id[1] && rs2_id == rd_exe));

    always_comb begin
        en           = '1;
        clr          = '0;
        pc_en        = 1'b1;
        abort        = 1'b0;
        set_to       = 1'b0;
        state_nx     = state;
        flush_cnt_nx = flush_cnt;
        mc_cnt_nx    = mc_cnt;
        if (trap_taken || mret_exec) begin
            clr          = '1;
            abort        = state == MC_BUSY;
            state_nx     = FLUSH;
            flush_cnt_nx = 4'(FLUSH_CYCLES);
            mc_cnt_nx    = '0;
        end else if (state == FLUSH) begin
            clr = '1;
            if (!stall_pipl) begin
                flush_cnt_nx = flush_cnt - 4'd1;
                if (flush_cnt <= 4'd1) begin
                    state_nx     = RUN;
                    flush_cnt_nx = '0;
                end
            end
        end else if (stall_pipl) begin
            // timeout counter keeps running while frozen, saturating so the check still fires
            en    = '0;
            pc_en = 1'b0;
            if (state == MC_BUSY && mc_cnt != MC_MAX)
                mc_cnt_nx = mc_cnt + 8'd1;
        end else if (redirect_mem) begin
            clr = BR_CLR;
            if (state == MC_BUSY) begin
                abort     = 1'b1;
                mc_cnt_nx = '0;
                state_nx  = RUN;
            end
        end else if ((state == MC_BUSY && !mc_done && mc_cnt != MC_MAX) ||
                     (state == RUN && mc_start_exe)) begin
            en        = FRZ_EN;
            clr       = FRZ_CLR;
            pc_en     = 1'b0;
            mc_cnt_nx = state == MC_BUSY ? mc_cnt + 8'd1 : 8'd0;
            state_nx  = MC_BUSY;
        end else begin
            // plain RUN, or leaving MC_BUSY by completion or timeout (mc_start_exe ignored here)
            if (state == MC_BUSY) begin
                abort     = !mc_done;
                set_to    = !mc_done;
                mc_cnt_nx = '0;
                state_nx  = RUN;
            end
            if (load_use) begin
                en    = LU_EN;
                clr   = LU_CLR;
                pc_en = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            flush_cnt  <= '0;
            mc_cnt     <= '0;
            mc_timeout <= 1'b0;
        end else begin
            state      <= state_nx;
            flush_cnt  <= flush_cnt_nx;
            mc_cnt     <= mc_cnt_nx;
            mc_timeout <= mc_timeout | set_to;
        end
    end

    assign stage_en  = reset_n ? en : '0;
    assign stage_clr = reset_n ? clr : '1;
    assign pc_reg_en = reset_n && pc_en;
    assign mc_abort  = reset_n && abort;
    assign fsm_state = state;

`ifdef PIPE_PERF_CNT_EN
    logic flush_evt;
    assign flush_evt = trap_taken || mret_exec || (state != FLUSH && !stall_pipl && redirect_mem);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            stall_cycles <= stall_cycles + 32'(!pc_en && state != FLUSH);
            flush_events <= flush_events + 32'(flush_evt);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb_pipe_flow_ctrl: scoreboard bench for pipe_flow_ctrl with directed scenarios and random traffic
module tb_pipe_flow_ctrl;
    localparam int NS  = 5;
    localparam int N   = NS - 1;
    localparam int EXE = 2;
    localparam int BR  = 3;
    localparam int FC  = 2;
    localparam int TO  = 8;

    logic clk = 1'b0;
    logic reset_n, mem_read_exe, mc_start_exe, mc_done, redirect_mem, stall_pipl, trap_taken, mret_exec;
    logic [4:0] rs1_id, rs2_id, rd_exe;
    logic [1:0] use_rs_id, fsm_state;
    logic [N-1:0] stage_en, stage_clr;
    logic pc_reg_en, mc_abort, mc_timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
    int unsigned m_stall = 0, m_fev = 0;
`endif

    pipe_flow_ctrl #(.NUM_STAGES(NS), .EXE_STAGE(EXE), .BR_STAGE(BR), .FLUSH_CYCLES(FC),
                     .MC_TIMEOUT(TO), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs_id(use_rs_id),
        .rd_exe(rd_exe), .mem_read_exe(mem_read_exe), .mc_start_exe(mc_start_exe), .mc_done(mc_done),
        .redirect_mem(redirect_mem), .stall_pipl(stall_pipl), .trap_taken(trap_taken),
        .mret_exec(mret_exec), .stage_en(stage_en), .stage_clr(stage_clr), .pc_reg_en(pc_reg_en),
        .mc_abort(mc_abort), .mc_timeout(mc_timeout), .fsm_state(fsm_state)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst_n, trap, mret, stall, redir, mcs, mcd, mrd;
        logic [4:0] rd, rs1, rs2;
        logic [1:0] urs;
    } stim_t;

    typedef struct {
        logic [N-1:0] en, clr;
        logic pc, ab, to;
        logic [1:0] st;
    } exp_t;

    stim_t nx;
    exp_t  sb[$];
    int n_cmp = 0, n_bad = 0, pushed = 0, popped = 0;

    // reference model: mode 0=run 1=multi-cycle wait 2=flush
    int m_mode = 0, m_left = 0, m_el = 0;
    bit m_to = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic idle();
        nx = '{rst_n: 1'b1, trap: 1'b0, mret: 1'b0, stall: 1'b0, redir: 1'b0, mcs: 1'b0, mcd: 1'b0,
               mrd: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, urs: 2'd0};
    endtask

    task automatic step();
        exp_t e;
        bit hz;
        int pm;
        @(negedge clk);
        reset_n = nx.rst_n; trap_taken = nx.trap; mret_exec = nx.mret; stall_pipl = nx.stall;
        redirect_mem = nx.redir; mc_start_exe = nx.mcs; mc_done = nx.mcd; mem_read_exe = nx.mrd;
        rd_exe = nx.rd; rs1_id = nx.rs1; rs2_id = nx.rs2; use_rs_id = nx.urs;
        #1;
        pm = m_mode;
        e.en = '1; e.clr = '0; e.pc = 1'b1; e.ab = 1'b0; e.st = 2'(m_mode); e.to = m_to;
        hz = nx.mrd && nx.rd != 0 && ((nx.urs[0] && nx.rs1 == nx.rd) || (nx.urs[1] && nx.rs2 == nx.rd));
        if (!nx.rst_n) begin
            e.en = '0; e.clr = '1; e.pc = 1'b0; e.st = 2'd0; e.to = 1'b0;
            m_mode = 0; m_left = 0; m_el = 0; m_to = 0;
`ifdef PIPE_PERF_CNT_EN
            m_stall = 0; m_fev = 0;
`endif
        end else begin
            if (nx.trap || nx.mret) begin
                e.clr = '1; e.ab = m_mode == 1;
                m_mode = 2; m_left = FC; m_el = 0;
            end else if (m_mode == 2) begin
                e.clr = '1;
                if (!nx.stall) begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            end else if (nx.stall) begin
                e.en = '0; e.pc = 1'b0;
                if (m_mode == 1 && m_el < TO - 1) m_el++;
            end else if (nx.redir) begin
                for (int k = 0; k < BR; k++) e.clr[k] = 1'b1;
                if (m_mode == 1) begin e.ab = 1'b1; m_mode = 0; m_el = 0; end
            end else if ((m_mode == 1 && !nx.mcd && m_el < TO - 1) || (m_mode == 0 && nx.mcs)) begin
                e.pc = 1'b0;
                for (int k = 0; k < EXE; k++) e.en[k] = 1'b0;
                e.clr[EXE] = 1'b1;
                m_el = (m_mode == 0) ? 0 : m_el + 1;
                m_mode = 1;
            end else begin
                if (m_mode == 1) begin
                    if (!nx.mcd) begin e.ab = 1'b1; m_to = 1; end
                    m_mode = 0; m_el = 0;
                end
                if (hz) begin
                    e.pc = 1'b0;
                    if (EXE >= 2) e.en[EXE-2] = 1'b0;
                    e.clr[EXE-1] = 1'b1;
                end
            end
`ifdef PIPE_PERF_CNT_EN
            if (!e.pc && pm != 2) m_stall++;
            if (nx.trap || nx.mret || (pm != 2 && !nx.stall && nx.redir)) m_fev++;
`endif
        end
        sb.push_back(e);
        pushed++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                popped++;
                chk("stage_en", 32'(stage_en), 32'(e.en));
                chk("stage_clr", 32'(stage_clr), 32'(e.clr));
                chk("pc_reg_en", 32'(pc_reg_en), 32'(e.pc));
                chk("mc_abort", 32'(mc_abort), 32'(e.ab));
                chk("fsm_state", 32'(fsm_state), 32'(e.st));
                chk("mc_timeout", 32'(mc_timeout), 32'(e.to));
            end
        end
    end

    initial begin
        reset_n = 1'b0; trap_taken = 1'b0; mret_exec = 1'b0; stall_pipl = 1'b0; redirect_mem = 1'b0;
        mc_start_exe = 1'b0; mc_done = 1'b0; mem_read_exe = 1'b0; rd_exe = '0; rs1_id = '0; rs2_id = '0;
        use_rs_id = '0;
        idle(); nx.rst_n = 1'b0; repeat (2) step();
        // load-use hazards and non-hazards
        idle(); nx.mrd = 1'b1; nx.rd = 5'd5; nx.rs1 = 5'd5; nx.urs = 2'b01; step();
        nx.rd = 5'd0; nx.rs1 = 5'd0; step();
        nx.rd = 5'd7; nx.rs2 = 5'd7; nx.urs = 2'b10; step();
        nx.urs = 2'b01; step();
        // multi-cycle completes, then mc_done in RUN is ignored
        idle(); nx.mcs = 1'b1; step();
        nx.mcs = 1'b0; repeat (6) step();
        nx.mcd = 1'b1; step();
        idle(); step();
        nx.mcd = 1'b1; step();
        // multi-cycle timeout
        idle(); nx.mcs = 1'b1; step();
        nx.mcs = 1'b0; repeat (10) step();
        // timeout reached while stalled fires on the first unstalled cycle
        nx.mcs = 1'b1; step();
        idle(); nx.stall = 1'b1; repeat (12) step();
        nx.stall = 1'b0; repeat (2) step();
        // trap in MC_BUSY under stall
        nx.mcs = 1'b1; step();
        idle(); step();
        nx.trap = 1'b1; nx.stall = 1'b1; step();
        nx.trap = 1'b0; repeat (2) step();
        nx.stall = 1'b0; repeat (4) step();
        // redirect with concurrent load-use, then redirect in MC_BUSY
        idle(); nx.redir = 1'b1; nx.mrd = 1'b1; nx.rd = 5'd3; nx.rs1 = 5'd3; nx.urs = 2'b11; step();
        idle(); nx.mrd = 1'b1; nx.rd = 5'd3; step();
        idle(); nx.mcs = 1'b1; step();
        idle(); step();
        nx.redir = 1'b1; step();
        // mret, then reset in the middle of FLUSH
        idle(); nx.mret = 1'b1; step();
        idle(); step();
        nx.rst_n = 1'b0; step();
        nx.rst_n = 1'b1; repeat (2) step();
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            nx.rst_n = ($urandom % 1000) >= 5;
            nx.trap  = ($urandom % 100) < 3;
            nx.mret  = ($urandom % 100) < 2;
            nx.stall = ($urandom % 100) < 15;
            nx.redir = ($urandom % 100) < 8;
            nx.mcs   = ($urandom % 100) < 12;
            nx.mcd   = ($urandom % 100) < 20;
            nx.mrd   = ($urandom % 100) < 35;
            nx.rd    = 5'($urandom % 4);
            nx.rs1   = 5'($urandom % 4);
            nx.rs2   = 5'($urandom % 4);
            nx.urs   = 2'($urandom % 4);
            step();
        end
        idle(); step();
        @(posedge clk);
        #1;
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, m_stall);
        chk("flush_events", flush_events, m_fev);
`endif
        @(negedge clk);
        #3;
        chk("drained", 32'(popped), 32'(pushed));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
